// File: rtl/mgmt_data_channel_responder_if.sv
// Payload type and the request / local-bus / response bundle of the data-channel responder.
package mgmt_data_channel_pkg;
  typedef struct packed {
    logic [15:0] reserved;
    logic [7:0]  command;
    logic [7:0]  tag;
    logic [7:0]  operation_status;
    logic [31:0] address;
    logic [3:0]  byte_en;
    logic [31:0] data;
  } Data_channel_payload_t;
endpackage

interface mgmt_data_channel_responder_if;
  import mgmt_data_channel_pkg::*;

  Data_channel_payload_t req;
  logic                  req_valid;
  logic                  req_dropped;
  logic [31:0]           bus_address;
  logic                  bus_write;
  logic                  bus_read;
  logic [31:0]           bus_wdata;
  logic [3:0]            bus_be;
  logic                  bus_waitrequest;
  logic [31:0]           bus_rdata;
  logic                  bus_rdvalid;
  Data_channel_payload_t resp;
  logic                  resp_valid;
  logic                  resp_ack;

  modport master (
    input  req, req_valid, bus_waitrequest, bus_rdata, bus_rdvalid, resp_ack,
    output req_dropped, bus_address, bus_write, bus_read, bus_wdata, bus_be, resp, resp_valid
  );

  modport slave (
    output req, req_valid, bus_waitrequest, bus_rdata, bus_rdvalid, resp_ack,
    input  req_dropped, bus_address, bus_write, bus_read, bus_wdata, bus_be, resp, resp_valid
  );
endinterface

// File: rtl/mgmt_data_channel_responder.sv
// Turns data-channel read/write requests into local-bus accesses and queues the
// completions in a first-word-fall-through response FIFO.
module mgmt_data_channel_responder
  import mgmt_data_channel_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int BUS_TIMEOUT = 255
) (
  input logic clk,
  input logic reset,
  input logic data_channel_rst,
  mgmt_data_channel_responder_if.master dc
);
  localparam int         PTR_W  = $clog2(FIFO_DEPTH);
  localparam int         CNT_W  = PTR_W + 1;
  localparam logic [7:0] TMO    = 8'(BUS_TIMEOUT);
  localparam logic [7:0] CMD_RD = 8'h00;
  localparam logic [7:0] CMD_WR = 8'h01;

  typedef enum logic [2:0] {IDLE, BUS_REQ, BUS_WAIT, BUILD, PUSH} state_t;

  state_t                state;
  logic [7:0]            cmd_q, tag_q, tmo_cnt;
  logic [31:0]           rdata_q;
  logic                  timed_out;
  Data_channel_payload_t entry;

  Data_channel_payload_t mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      count;
  logic                  full, push, pop;

  assign full          = count == CNT_W'(FIFO_DEPTH);
  assign push          = (state == PUSH) && !full;
  assign pop           = dc.resp_ack && (count != '0);
  assign dc.resp_valid = count != '0;
  assign dc.resp       = dc.resp_valid ? mem[rd_ptr] : '0;

  // Address, byte enables and write data stay parked on the bus registers for the
  // whole transaction, so they double as the latched request fields.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      cmd_q          <= '0;
      tag_q          <= '0;
      tmo_cnt        <= '0;
      rdata_q        <= '0;
      timed_out      <= 1'b0;
      entry          <= '0;
      dc.bus_address <= '0;
      dc.bus_wdata   <= '0;
      dc.bus_be      <= '0;
      dc.bus_write   <= 1'b0;
      dc.bus_read    <= 1'b0;
      dc.req_dropped <= 1'b0;
    end else if (data_channel_rst) begin
      state          <= IDLE;
      tmo_cnt        <= '0;
      dc.bus_write   <= 1'b0;
      dc.bus_read    <= 1'b0;
      dc.req_dropped <= dc.req_valid;
    end else begin
      dc.req_dropped <= dc.req_valid && (state != IDLE);
      case (state)
        IDLE: if (dc.req_valid) begin
          if (dc.req.command == CMD_RD || dc.req.command == CMD_WR) begin
            state          <= BUS_REQ;
            cmd_q          <= dc.req.command;
            tag_q          <= dc.req.tag;
            tmo_cnt        <= '0;
            timed_out      <= 1'b0;
            dc.bus_address <= dc.req.address;
            dc.bus_be      <= dc.req.byte_en;
            dc.bus_wdata   <= dc.req.data;
            dc.bus_write   <= dc.req.command == CMD_WR;
            dc.bus_read    <= dc.req.command == CMD_RD;
          end else begin
            dc.req_dropped <= 1'b1;
          end
        end
        BUS_REQ: begin
          tmo_cnt <= tmo_cnt + 8'd1;
          if (!dc.bus_waitrequest) begin
            dc.bus_write <= 1'b0;
            dc.bus_read  <= 1'b0;
            state        <= (cmd_q == CMD_WR) ? BUILD : BUS_WAIT;
          end else if (tmo_cnt == TMO) begin
            dc.bus_write <= 1'b0;
            dc.bus_read  <= 1'b0;
            timed_out    <= 1'b1;
            state        <= BUILD;
          end
        end
        BUS_WAIT: begin
          tmo_cnt <= tmo_cnt + 8'd1;
          if (dc.bus_rdvalid) begin
            rdata_q <= dc.bus_rdata;
            state   <= BUILD;
          end else if (tmo_cnt == TMO) begin
            timed_out <= 1'b1;
            state     <= BUILD;
          end
        end
        BUILD: begin
          entry.reserved         <= '0;
          entry.command          <= cmd_q + 8'd2;
          entry.tag              <= tag_q;
          entry.operation_status <= timed_out ? 8'h01 : 8'h00;
          entry.address          <= dc.bus_address;
          entry.byte_en          <= dc.bus_be;
          entry.data             <= timed_out ? 32'h0 : (cmd_q == CMD_WR) ? dc.bus_wdata : rdata_q;
          state                  <= PUSH;
        end
        PUSH:    if (!full) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else if (data_channel_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= entry;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mgmt_data_channel_responder.sv
// Randomized bench: a behavioural bus slave plus a transaction-level response model.
module tb_mgmt_data_channel_responder;
  import mgmt_data_channel_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic dcr = 1'b0;
  always #5 clk = ~clk;

  mgmt_data_channel_responder_if dc();

  mgmt_data_channel_responder #(.FIFO_DEPTH(4), .BUS_TIMEOUT(255)) dut (
    .clk(clk), .reset(reset), .data_channel_rst(dcr), .dc(dc)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Bus slave: cfg_ws stall cycles per access, read data cfg_rdly cycles after
  // acceptance (0 = next cycle, negative = never).
  int          cfg_ws = 0, cfg_rdly = 0;
  logic [31:0] cfg_rval = '0;
  int          acc_n = 0, strobe_n = 0, ws_left = 0, rd_cd = 0;
  bit          rd_pend = 0;
  logic [31:0] acc_addr = '0, acc_wdata = '0;
  logic [3:0]  acc_be = '0;
  logic        acc_we = 1'b0;

  always begin
    @(posedge clk);
    #1;
    dc.bus_rdvalid = 1'b0;
    if (reset) rd_pend = 0;
    else if (rd_pend) begin
      if (rd_cd == 0) begin
        dc.bus_rdvalid = 1'b1;
        dc.bus_rdata   = cfg_rval;
        rd_pend        = 0;
      end else rd_cd--;
    end
    if (dc.bus_read || dc.bus_write) begin
      strobe_n++;
      if (ws_left > 0) begin
        dc.bus_waitrequest = 1'b1;
        ws_left--;
      end else begin
        dc.bus_waitrequest = 1'b0;
        acc_n++;
        acc_addr  = dc.bus_address;
        acc_wdata = dc.bus_wdata;
        acc_be    = dc.bus_be;
        acc_we    = dc.bus_write;
        if (dc.bus_read && cfg_rdly >= 0) begin
          rd_pend = 1;
          rd_cd   = cfg_rdly;
        end
      end
    end else begin
      dc.bus_waitrequest = 1'b0;
      ws_left = cfg_ws;
    end
  end

  function automatic Data_channel_payload_t rnd_req(input logic [7:0] cmd);
    Data_channel_payload_t p;
    p.reserved         = 16'($urandom);
    p.command          = cmd;
    p.tag              = 8'($urandom);
    p.operation_status = 8'($urandom);
    p.address          = $urandom;
    p.byte_en          = 4'($urandom);
    p.data             = $urandom;
    return p;
  endfunction

  // Reference: what a completion for request p must look like.
  function automatic Data_channel_payload_t model(input Data_channel_payload_t p,
                                                  input logic [31:0] rv, input bit tmo);
    Data_channel_payload_t e;
    e                  = '0;
    e.command          = p.command + 8'd2;
    e.tag              = p.tag;
    e.operation_status = tmo ? 8'h01 : 8'h00;
    e.address          = p.address;
    e.byte_en          = p.byte_en;
    e.data             = tmo ? 32'h0 : (p.command == 8'h01) ? p.data : rv;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input Data_channel_payload_t p);
    dc.req       = p;
    dc.req_valid = 1'b1;
    tick();
    dc.req_valid = 1'b0;
  endtask

  task automatic ack();
    dc.resp_ack = 1'b1;
    tick();
    dc.resp_ack = 1'b0;
  endtask

  task automatic wait_resp(output int n, output bit ok);
    n  = 0;
    ok = 0;
    while (n < 600) begin
      if (dc.resp_valid) begin
        ok = 1;
        break;
      end
      tick();
      n++;
    end
  endtask

  task automatic txn(input Data_channel_payload_t p, input logic [31:0] rv,
                     input int ws, input int rdly);
    int n, a0, s0;
    bit ok, tmo, is_wr;
    Data_channel_payload_t e;
    is_wr    = p.command == 8'h01;
    tmo      = (p.command == 8'h00) && (rdly < 0);
    cfg_ws   = ws;
    cfg_rdly = rdly;
    cfg_rval = rv;
    tick();
    a0 = acc_n;
    s0 = strobe_n;
    send(p);
    if (p.command > 8'h01) begin
      chk("drop_pulse", 128'(dc.req_dropped), 128'(1));
      tick();
      chk("drop_one_cycle", 128'(dc.req_dropped), 128'(0));
      repeat (3) tick();
      chk("drop_no_bus", 128'(acc_n - a0), 128'(0));
      chk("drop_no_resp", 128'(dc.resp_valid), 128'(0));
      return;
    end
    wait_resp(n, ok);
    chk("resp_seen", 128'(ok), 128'(1));
    if (!ok) return;
    if (ws == 0 && rdly == 0) chk("latency", 128'(n), 128'(is_wr ? 3 : 4));
    if (tmo) chk("tmo_window", 128'(n >= 255 && n <= 262), 128'(1));
    e = model(p, rv, tmo);
    chk("resp", 128'(dc.resp), 128'(e));
    chk("bus_accesses", 128'(acc_n - a0), 128'(1));
    chk("bus_fields", {acc_we, acc_be, acc_addr, is_wr ? acc_wdata : 32'h0},
        {is_wr, p.byte_en, p.address, is_wr ? p.data : 32'h0});
    chk("strobe_cycles", 128'(strobe_n - s0), 128'(ws + 1));
    chk("strobes_idle", 128'({dc.bus_read, dc.bus_write}), 128'(0));
    ack();
    chk("drained", 128'(dc.resp_valid), 128'(0));
  endtask

  Data_channel_payload_t exp_q[$];

  task automatic queue_read(input logic [7:0] tag);
    Data_channel_payload_t p;
    logic [31:0] rv;
    p        = rnd_req(8'h00);
    p.tag    = tag;
    rv       = $urandom;
    cfg_ws   = 0;
    cfg_rdly = 0;
    cfg_rval = rv;
    tick();
    send(p);
    exp_q.push_back(model(p, rv, 0));
    repeat (8) tick();
  endtask

  initial begin
    Data_channel_payload_t p, e;
    int n, a0;
    bit ok;
    dc.req = '0; dc.req_valid = 1'b0; dc.resp_ack = 1'b0;
    dc.bus_waitrequest = 1'b0; dc.bus_rdata = '0; dc.bus_rdvalid = 1'b0;

    repeat (2) tick();
    chk("rst_strobes", 128'({dc.bus_read, dc.bus_write}), 128'(0));
    chk("rst_bus", {dc.bus_address, dc.bus_wdata, dc.bus_be}, 128'(0));
    chk("rst_resp", 128'(dc.resp), 128'(0));
    chk("rst_flags", 128'({dc.resp_valid, dc.req_dropped}), 128'(0));
    reset = 1'b0;
    tick();

    // Directed read and stalled write.
    p = rnd_req(8'h00); p.tag = 8'h5A; p.address = 32'h100;
    txn(p, 32'hDEADBEEF, 0, 0);
    txn(rnd_req(8'h01), $urandom, 3, 0);
    // Read that never gets data.
    txn(rnd_req(8'h00), $urandom, 0, -1);
    // Unknown command.
    txn(rnd_req(8'h07), $urandom, 0, 0);

    // Pop on empty must not underflow.
    ack();
    chk("ack_empty", 128'(dc.resp_valid), 128'(0));

    // Request arriving while a read waits for data.
    p = rnd_req(8'h00);
    cfg_ws = 0; cfg_rdly = 3; cfg_rval = $urandom;
    tick();
    a0 = acc_n;
    send(p);
    tick();
    send(rnd_req(8'h00));
    chk("busy_drop", 128'(dc.req_dropped), 128'(1));
    wait_resp(n, ok);
    chk("busy_resp_seen", 128'(ok), 128'(1));
    chk("busy_resp", 128'(dc.resp), 128'(model(p, cfg_rval, 0)));
    chk("busy_one_access", 128'(acc_n - a0), 128'(1));
    ack();

    // Fill the queue; the fifth completion must wait for space.
    for (int k = 0; k < 5; k++) queue_read(8'(8'h10 + k));
    chk("full_head", 128'(dc.resp), 128'(exp_q[0]));
    send(rnd_req(8'h01));
    chk("full_drop", 128'(dc.req_dropped), 128'(1));
    for (int k = 0; k < 5; k++) begin
      e = exp_q.pop_front();
      chk("order_valid", 128'(dc.resp_valid), 128'(1));
      chk("order_entry", 128'(dc.resp), 128'(e));
      ack();
    end
    chk("order_drained", 128'(dc.resp_valid), 128'(0));

    // Channel flush with queued entries and a read stuck in BUS_WAIT.
    exp_q.delete();
    for (int k = 0; k < 3; k++) queue_read(8'(8'h20 + k));
    cfg_rdly = -1;
    tick();
    send(rnd_req(8'h00));
    repeat (3) tick();
    dcr = 1'b1;
    tick();
    dcr = 1'b0;
    chk("flush_empty", 128'(dc.resp_valid), 128'(0));
    chk("flush_strobe", 128'(dc.bus_read), 128'(0));
    repeat (300) tick();
    chk("flush_no_late", 128'(dc.resp_valid), 128'(0));
    exp_q.delete();
    txn(rnd_req(8'h00), $urandom, 0, 0);

    // Async reset in the middle of a read.
    cfg_rdly = -1;
    tick();
    send(rnd_req(8'h00));
    repeat (2) tick();
    #2 reset = 1'b1;
    #1 chk("arst_strobe", 128'(dc.bus_read), 128'(0));
    repeat (2) tick();
    reset = 1'b0;
    repeat (300) tick();
    chk("arst_no_resp", 128'(dc.resp_valid), 128'(0));

    // Random traffic.
    for (int i = 0; i < 25; i++) begin
      int r, ws, rd;
      logic [7:0] c;
      r  = $urandom_range(0, 9);
      c  = (r < 4) ? 8'h00 : (r < 8) ? 8'h01 : 8'($urandom_range(2, 255));
      ws = $urandom_range(0, 3);
      rd = ($urandom_range(0, 7) == 0) ? -1 : $urandom_range(0, 3);
      txn(rnd_req(c), $urandom, ws, rd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
